acc_cpu_core: RTL and testbench

ACC_CPU_CORE -- requirements
Module: acc_cpu_core

---
 rtl/acc_cpu_core.sv | 179 +++++++++++++++++
 tb/tb_acc_cpu_core.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_cpu_core.sv
// rtl/acc_cpu_core.sv - accumulator CPU core with a fetch/decode/exec/halt sequencer
module acc_cpu_core #(
  parameter int DW = 16,
  parameter int AW = 10,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  output logic [AW-1:0] adr_bus,
  output logic          rd_mem,
  output logic          wr_mem,
  input  logic          mem_ready,
  inout  wire  [DW-1:0] data_bus,
  output logic          halted
);
  typedef enum logic [1:0] {S_FETCH, S_DECODE, S_EXEC, S_HALT} state_t;

  localparam logic [5:0] OP_LDA = 6'h01;
  localparam logic [5:0] OP_STA = 6'h02;
  localparam logic [5:0] OP_ADD = 6'h03;
  localparam logic [5:0] OP_ADC = 6'h04;
  localparam logic [5:0] OP_LDI = 6'h05;
  localparam logic [5:0] OP_JMP = 6'h06;
  localparam logic [5:0] OP_JZ  = 6'h07;
  localparam logic [5:0] OP_JC  = 6'h08;
  localparam logic [5:0] OP_INC = 6'h09;
  localparam logic [5:0] OP_CMP = 6'h0A;
  localparam logic [5:0] OP_SHL = 6'h0B;
  localparam logic [5:0] OP_SHR = 6'h0C;
  localparam logic [5:0] OP_STC = 6'h0D;
  localparam logic [5:0] OP_CLC = 6'h0E;
  localparam logic [5:0] OP_HLT = 6'h0F;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [DW-1:0] ir_q, ir_d;
  logic [DW-1:0] ac_q, ac_d;
  logic          c_q, c_d;
  logic          z_q, z_d;

  logic [5:0]    opcode;
  logic [DW-7:0] operand;
  logic [AW-1:0] op_adr;
  logic          is_mem_op;
  logic          ac_wr;
  logic [DW-1:0] add_b;
  logic          add_cin;
  logic [DW:0]   sum;

  assign opcode    = ir_q[DW-1:DW-6];
  assign operand   = ir_q[DW-7:0];
  assign op_adr    = operand[AW-1:0];
  assign is_mem_op = opcode inside {OP_LDA, OP_STA, OP_ADD, OP_ADC};
  assign data_bus  = wr_mem ? ac_q : 'z;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      ac_q    <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b1;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ac_q    <= ac_d;
      c_q     <= c_d;
      z_q     <= z_d;
    end
  end

  // One adder serves ADD, ADC and INC; INC ignores the bus so stray bus values never leak in.
  always_comb begin
    add_b   = data_bus;
    add_cin = 1'b0;
    if (opcode == OP_ADC) begin
      add_cin = c_q;
    end else if (opcode == OP_INC) begin
      add_b   = '0;
      add_cin = 1'b1;
    end
    sum = {1'b0, ac_q} + {1'b0, add_b} + {{DW{1'b0}}, add_cin};
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    ac_d    = ac_q;
    c_d     = c_q;
    z_d     = z_q;
    ac_wr   = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        if (mem_ready) begin
          ir_d    = data_bus;
          pc_d    = pc_q + 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        state_d = S_FETCH;
        case (opcode)
          OP_LDA: begin
            if (mem_ready) begin
              ac_d  = data_bus;
              ac_wr = 1'b1;
            end else begin
              state_d = S_EXEC;
            end
          end
          OP_STA: if (!mem_ready) state_d = S_EXEC;
          OP_ADD, OP_ADC: begin
            if (mem_ready) begin
              {c_d, ac_d} = sum;
              ac_wr       = 1'b1;
            end else begin
              state_d = S_EXEC;
            end
          end
          OP_LDI: begin
            ac_d  = {6'b0, operand};
            ac_wr = 1'b1;
          end
          OP_JMP: pc_d = op_adr;
          OP_JZ:  if (z_q) pc_d = op_adr;
          OP_JC:  if (c_q) pc_d = op_adr;
          OP_INC: begin
            {c_d, ac_d} = sum;
            ac_wr       = 1'b1;
          end
          OP_CMP: begin
            ac_d  = ~ac_q;
            ac_wr = 1'b1;
          end
          OP_SHL: begin
            c_d   = ac_q[DW-1];
            ac_d  = {ac_q[DW-2:0], 1'b0};
            ac_wr = 1'b1;
          end
          OP_SHR: begin
            c_d   = ac_q[0];
            ac_d  = {1'b0, ac_q[DW-1:1]};
            ac_wr = 1'b1;
          end
          OP_STC: c_d = 1'b1;
          OP_CLC: c_d = 1'b0;
          OP_HLT: state_d = S_HALT;
          default: ;
        endcase
        if (ac_wr) z_d = (ac_d == '0);
      end
      S_HALT: ;
      default: state_d = S_FETCH;
    endcase
  end

  // Requests are masked while reset is high so an abandoned access never reaches memory.
  always_comb begin
    adr_bus = pc_q;
    rd_mem  = 1'b0;
    wr_mem  = 1'b0;
    halted  = (state_q == S_HALT) && !reset;
    case (state_q)
      S_FETCH: rd_mem = !reset;
      S_EXEC: begin
        if (is_mem_op) begin
          adr_bus = op_adr;
          rd_mem  = !reset && (opcode != OP_STA);
          wr_mem  = !reset && (opcode == OP_STA);
        end
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_acc_cpu_core.sv
// tb/tb_acc_cpu_core.sv - directed and randomized checks of acc_cpu_core against an instruction-level model
module tb_acc_cpu_core;
  localparam int DW = 16;
  localparam int AW = 10;
  localparam int MW = 1 << AW;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } acc_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          mem_ready = 1'b1;
  logic [AW-1:0] adr_bus;
  logic          rd_mem, wr_mem, halted;
  wire  [DW-1:0] data_bus;
  logic [DW-1:0] mem  [MW];
  logic [DW-1:0] imem [MW];

  logic          reset2 = 1'b1;
  logic [5:0]    adr_bus2;
  logic          rd_mem2, wr_mem2, halted2;
  wire  [11:0]   data_bus2;
  logic [11:0]   mem2 [64];

  int            n_vec = 0;
  int            n_bad = 0;
  int            cyc;
  acc_t          exp_q[$];
  acc_t          obs_q[$];

  logic          s_rd, s_wr, s_halt;
  logic [AW-1:0] s_adr;
  logic [DW-1:0] s_dat;
  logic          p_pend = 1'b0;
  logic          p_rd, p_wr;
  logic [AW-1:0] p_adr;
  logic [DW-1:0] p_dat;

  logic [AW-1:0] iss_pc;
  logic [DW-1:0] iss_ac;
  logic          iss_c, iss_z, iss_halt;
  int            iss_n;

  assign data_bus  = rd_mem  ? mem[adr_bus]   : 'z;
  assign data_bus2 = rd_mem2 ? mem2[adr_bus2] : 'z;

  acc_cpu_core #(.DW(DW), .AW(AW), .RESET_PC('0)) dut (
    .clk(clk), .reset(reset), .adr_bus(adr_bus), .rd_mem(rd_mem), .wr_mem(wr_mem),
    .mem_ready(mem_ready), .data_bus(data_bus), .halted(halted)
  );

  acc_cpu_core #(.DW(12), .AW(6), .RESET_PC('0)) dut2 (
    .clk(clk), .reset(reset2), .adr_bus(adr_bus2), .rd_mem(rd_mem2), .wr_mem(wr_mem2),
    .mem_ready(1'b1), .data_bus(data_bus2), .halted(halted2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic acc_t mk(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    acc_t r;
    r.wr = wr;
    r.a  = a;
    r.d  = d;
    return r;
  endfunction

  function automatic logic [DW-1:0] ins(input int op, input int opd);
    return {op[5:0], opd[DW-7:0]};
  endfunction

  // One clock: sample at the falling edge, act as the memory, return just after the rising edge.
  task automatic tick(input logic rdy);
    mem_ready = rdy;
    @(negedge clk);
    s_rd   = rd_mem;
    s_wr   = wr_mem;
    s_adr  = adr_bus;
    s_dat  = data_bus;
    s_halt = halted;
    chk("rd_wr_exclusive", 32'(s_rd & s_wr), 32'd0);
    if (p_pend && !reset) begin
      chk("hold_rd", 32'(s_rd), 32'(p_rd));
      chk("hold_wr", 32'(s_wr), 32'(p_wr));
      chk("hold_adr", 32'(s_adr), 32'(p_adr));
      if (s_wr) chk("hold_data", 32'(s_dat), 32'(p_dat));
    end
    if (!reset && rdy && (s_rd || s_wr)) begin
      obs_q.push_back(mk(s_wr, s_adr, s_wr ? s_dat : '0));
      if (s_wr) mem[s_adr] = s_dat;
    end
    p_pend = !reset && !rdy && (s_rd || s_wr);
    p_rd   = s_rd;
    p_wr   = s_wr;
    p_adr  = s_adr;
    p_dat  = s_dat;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick(1'b1);
    tick(1'b1);
    chk("reset_rd", 32'(s_rd), 32'd0);
    chk("reset_wr", 32'(s_wr), 32'd0);
    chk("reset_halted", 32'(s_halt), 32'd0);
    reset  = 1'b0;
    p_pend = 1'b0;
    obs_q.delete();
  endtask

  task automatic clear_mem();
    for (int i = 0; i < MW; i++) mem[i] = '0;
  endtask

  // Instruction-level reference: walks imem and lists every bus access the program makes.
  task automatic iss_run();
    logic [DW-1:0] ir, m;
    logic [5:0]    op;
    logic [AW-1:0] a;
    int unsigned   s;
    exp_q.delete();
    iss_pc = '0; iss_ac = '0; iss_c = 1'b0; iss_z = 1'b1; iss_halt = 1'b0; iss_n = 0;
    while (!iss_halt && iss_n < 200) begin
      ir = imem[iss_pc];
      exp_q.push_back(mk(1'b0, iss_pc, '0));
      iss_pc = iss_pc + 1'b1;
      iss_n++;
      op = ir[DW-1:DW-6];
      a  = ir[AW-1:0];
      case (op)
        6'h01: begin
          exp_q.push_back(mk(1'b0, a, '0));
          iss_ac = imem[a];
          iss_z  = (iss_ac == 0);
        end
        6'h02: begin
          exp_q.push_back(mk(1'b1, a, iss_ac));
          imem[a] = iss_ac;
        end
        6'h03, 6'h04: begin
          exp_q.push_back(mk(1'b0, a, '0));
          m      = imem[a];
          s      = 32'(iss_ac) + 32'(m) + ((op == 6'h04) ? 32'(iss_c) : 32'd0);
          iss_c  = s[DW];
          iss_ac = s[DW-1:0];
          iss_z  = (iss_ac == 0);
        end
        6'h05: begin iss_ac = {6'b0, ir[DW-7:0]}; iss_z = (iss_ac == 0); end
        6'h06: iss_pc = a;
        6'h07: if (iss_z) iss_pc = a;
        6'h08: if (iss_c) iss_pc = a;
        6'h09: begin
          s      = 32'(iss_ac) + 32'd1;
          iss_c  = s[DW];
          iss_ac = s[DW-1:0];
          iss_z  = (iss_ac == 0);
        end
        6'h0A: begin iss_ac = ~iss_ac; iss_z = (iss_ac == 0); end
        6'h0B: begin iss_c = iss_ac[DW-1]; iss_ac = iss_ac << 1; iss_z = (iss_ac == 0); end
        6'h0C: begin iss_c = iss_ac[0]; iss_ac = iss_ac >> 1; iss_z = (iss_ac == 0); end
        6'h0D: iss_c = 1'b1;
        6'h0E: iss_c = 1'b0;
        6'h0F: iss_halt = 1'b1;
        default: ;
      endcase
    end
  endtask

  task automatic run_prog(input string tag, input logic rnd, input int max_cyc);
    imem = mem;
    iss_run();
    apply_reset();
    cyc = 0;
    while (!halted && cyc < max_cyc) begin
      tick(rnd ? 1'($urandom_range(0, 3) != 0) : 1'b1);
      cyc++;
    end
    chk({tag, "_halted"}, 32'(halted), 32'(iss_halt));
    chk({tag, "_trace_len"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk({tag, "_access"}, 32'(obs_q[i]), 32'(exp_q[i]));
    chk({tag, "_ac"}, 32'(dut.ac_q), 32'(iss_ac));
    chk({tag, "_c"}, 32'(dut.c_q), 32'(iss_c));
    chk({tag, "_z"}, 32'(dut.z_q), 32'(iss_z));
    chk({tag, "_pc"}, 32'(dut.pc_q), 32'(iss_pc));
    if (!rnd) chk({tag, "_cycles"}, 32'(cyc), 32'(3 * iss_n));
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem2[i] = '0;
    mem2[0] = 12'h048;
    mem2[1] = 12'h2C0;
    mem2[2] = 12'hFC0;
    mem2[3] = 12'h3C0;
    mem2[8] = 12'h800;

    // LDI / INC / HLT with a ready memory
    clear_mem();
    mem[0] = ins(5, 'h3FF);
    mem[1] = ins(9, 0);
    mem[2] = ins(15, 0);
    run_prog("inc", 1'b0, 50);
    chk("inc_halt_cycle", 32'(cyc), 32'd9);
    chk("inc_ac_value", 32'(dut.ac_q), 32'h0400);
    chk("inc_z_value", 32'(dut.z_q), 32'd0);
    chk("inc_c_value", 32'(dut.c_q), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick(1'($urandom_range(0, 1)));
      chk("halt_rd", 32'(s_rd), 32'd0);
      chk("halt_wr", 32'(s_wr), 32'd0);
      chk("halt_flag", 32'(s_halt), 32'd1);
      chk("halt_ac_frozen", 32'(dut.ac_q), 32'h0400);
    end

    // carry chain: ADD overflow then ADC
    clear_mem();
    mem['h100] = 'hFFFF;
    mem['h101] = 'h0001;
    mem[0] = ins(1, 'h100);
    mem[1] = ins(3, 'h101);
    mem[2] = ins(2, 'h102);
    mem[3] = ins(8, 5);
    mem[4] = ins(15, 0);
    mem[5] = ins(7, 7);
    mem[6] = ins(15, 0);
    mem[7] = ins(4, 'h101);
    mem[8] = ins(2, 'h103);
    mem[9] = ins(15, 0);
    run_prog("carry", 1'b0, 100);
    chk("carry_add_sum", 32'(mem['h102]), 32'h0000);
    chk("carry_adc_sum", 32'(mem['h103]), 32'h0002);
    chk("carry_adc_c", 32'(dut.c_q), 32'd0);
    chk("carry_end_pc", 32'(dut.pc_q), 32'd10);

    // STA held off by memory for three cycles
    clear_mem();
    mem[0] = ins(5, 'h155);
    mem[1] = ins(2, 'h020);
    mem[2] = ins(15, 0);
    apply_reset();
    repeat (5) tick(1'b1);
    for (int i = 0; i < 4; i++) begin
      tick(i == 3);
      chk("stall_wr", 32'(s_wr), 32'd1);
      chk("stall_adr", 32'(s_adr), 32'h020);
      chk("stall_data", 32'(s_dat), 32'h0155);
    end
    tick(1'b1);
    chk("stall_next_fetch_rd", 32'(s_rd), 32'd1);
    chk("stall_next_fetch_adr", 32'(s_adr), 32'd2);
    chk("stall_mem", 32'(mem['h020]), 32'h0155);

    // PC wrap and JZ both ways
    clear_mem();
    mem[0]     = ins(7, 'h3FF);
    mem['h3FF] = ins(5, 1);
    mem[1]     = ins(7, 'h100);
    mem[2]     = ins(5, 0);
    mem[3]     = ins(7, 'h100);
    mem['h100] = ins(15, 0);
    run_prog("wrap", 1'b0, 100);
    chk("wrap_fetch_count", 32'(obs_q.size()), 32'd7);
    if (obs_q.size() >= 7) begin
      chk("wrap_fetch_top", 32'(obs_q[1].a), 32'h3FF);
      chk("wrap_fetch_zero", 32'(obs_q[2].a), 32'h000);
      chk("wrap_jz_not_taken", 32'(obs_q[4].a), 32'h002);
      chk("wrap_jz_taken", 32'(obs_q[6].a), 32'h100);
    end

    // reset in the middle of a stalled store
    clear_mem();
    mem[0] = ins(5, 7);
    mem[1] = ins(2, 'h020);
    apply_reset();
    repeat (5) tick(1'b1);
    tick(1'b0);
    chk("midrst_wr_before", 32'(s_wr), 32'd1);
    reset = 1'b1;
    tick(1'b0);
    chk("midrst_wr_during", 32'(s_wr), 32'd0);
    reset = 1'b0;
    chk("midrst_ac", 32'(dut.ac_q), 32'd0);
    chk("midrst_z", 32'(dut.z_q), 32'd1);
    p_pend = 1'b0;
    tick(1'b0);
    chk("midrst_wr_after", 32'(s_wr), 32'd0);
    chk("midrst_fetch_rd", 32'(s_rd), 32'd1);
    chk("midrst_fetch_adr", 32'(s_adr), 32'd0);
    chk("midrst_no_write", 32'(mem['h020]), 32'd0);

    // random forward-branching programs with a randomly stalling memory
    for (int t = 0; t < 20; t++) begin
      clear_mem();
      for (int i = 0; i < 32; i++) begin
        int k, op, opd;
        k  = int'($urandom_range(0, 18));
        op = (k < 16) ? k : int'($urandom_range(16, 63));
        if (op >= 1 && op <= 4) opd = 'h100 + int'($urandom_range(0, 15));
        else if (op >= 6 && op <= 8) opd = int'($urandom_range(i + 1, 32));
        else opd = int'($urandom_range(0, MW - 1));
        mem[i] = ins(op, opd);
      end
      mem[32] = ins(15, 0);
      for (int j = 0; j < 16; j++) mem['h100 + j] = DW'($urandom);
      run_prog("rand", 1'b1, 2000);
    end

    // narrow build: SHL out of the top bit, then an undefined opcode
    reset2 = 1'b1;
    tick(1'b1);
    tick(1'b1);
    reset2 = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick(1'b1);
      if (i == 11) chk("narrow_not_halted", 32'(halted2), 32'd0);
    end
    chk("narrow_halted", 32'(halted2), 32'd1);
    chk("narrow_ac", 32'(dut2.ac_q), 32'h000);
    chk("narrow_c", 32'(dut2.c_q), 32'd1);
    chk("narrow_z", 32'(dut2.z_q), 32'd1);
    chk("narrow_wr", 32'(wr_mem2), 32'd0);
    chk("narrow_rd", 32'(rd_mem2), 32'd0);
    chk("narrow_adr", 32'(adr_bus2), 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
